trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
//  Machine-mode interrupt/trap sequencer; generates interrupt, is_mret-qualified epc_taken and PC redirect consumed by the hazard/flush unit and IF PC mux.
//  Owns mstatus/mie/mip/mtvec/mepc/mcause, serves CSR read/write from EX, and sequences trap entry and MRET return.
//  Sits beside the EX stage of the 2-stage RV32I pipeline.
// PARAMETERS
//  XLEN        32     data/PC width
//  RESET_PC    32'h0  reset value of mtvec and mepc
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     synchronous, active-high reset
//  timer_irq      in   1     machine timer interrupt line, level
//  ext_irq        in   1     machine external interrupt line, level
//  pc_ex          in   XLEN  PC of instruction in EX
//  ex_valid       in   1     EX holds a real (non-flushed) instruction
//  pc_if          in   XLEN  PC of instruction in IF
//  ld_stall       in   1     load-use stall active (stall_ex from hazard unit)
//  is_mret        in   1     MRET decoded in EX
//  csr_op         in   2     00 none, 01 RW, 10 RS, 11 RC
//  csr_addr       in   12    CSR address
//  csr_wdata      in   XLEN  rs1/zimm operand
//  csr_rdata      out  XLEN  old CSR value, combinational
//  interrupt      out  1     trap entry this cycle (flush + stall both stages)
//  epc_taken      out  1     redirect active; overrides any br_taken this cycle
//  redirect_pc    out  XLEN  target PC, valid when epc_taken=1
// BEHAVIOUR
//  Reset: state=RUN; mstatus, mie, mip, mcause = 0; mtvec, mepc = RESET_PC; interrupt, epc_taken = 0; redirect_pc = 0.
//  mip: MEIP(11)/MTIP(7) registered from ext_irq/timer_irq every cycle (1-cycle latency); read-only, writes ignored.
//  pend = mstatus.MIE(3) & |(mie & mip). Priority external (code 11) > timer (code 7).
//  FSM RUN:
//   - pend & ~ld_stall -> interrupt=1 (combinational), next REDIRECT. Registered:
//     mepc <= ex_valid ? pc_ex : pc_if; mcause <= {1'b1,27'b0,code}; MPIE(7) <= MIE; MIE <= 0.
//   - pend & ld_stall -> no entry; retried each cycle until ld_stall=0.
//   - else is_mret & ex_valid -> epc_taken=1, redirect_pc=mepc same cycle; MIE <= MPIE, MPIE <= 1; stay RUN.
//  FSM REDIRECT (1 cycle): epc_taken=1, redirect_pc={mtvec[31:2],2'b00} (direct mode only); next RUN; no new entry, is_mret ignored.
//  Simultaneous events:
//   - interrupt + is_mret: interrupt wins; mepc = MRET's pc_ex, MRET re-executes after handler.
//   - interrupt + csr_op!=0: CSR write suppressed (instruction re-executes); csr_rdata still driven.
//   - CSR write to mstatus.MIE same cycle as pend: pend uses pre-write MIE.
//  CSR access: csr_rdata = current value (0 for unimplemented addr); next = RW: wdata, RS: old|wdata, RC: old&~wdata.
//   Write only if ex_valid & ~ld_stall. mtvec[1:0] and mepc[1:0] forced 0 on write.
//   Unimplemented addresses: read 0, write ignored.
//  Reset mid-REDIRECT: returns to RUN, epc_taken=0 next cycle, no redirect.
// STRUCTURE
//  trap_pkg: CSR address localparams (0x300,0x304,0x305,0x341,0x342,0x344), bit indices MIE/MPIE/MEIx/MTIx,
//   cause codes, csr_op enum, state enum {RUN,REDIRECT}.
//  Sub-module mcsr_regs: CSR storage + read mux + RW/RS/RC update; trap_ctrl holds FSM, priority and entry/return updates.
// TESTING
//  1 Reset: rst=1 two cycles -> all outputs 0, csr_rdata at 0x305 = RESET_PC.
//  2 Timer entry: mtvec=0x100, mie=0x80, mstatus=0x8, timer_irq=1, pc_ex=0x40 ex_valid=1 -> interrupt 1 cycle,
//    next cycle epc_taken=1 redirect_pc=0x100; mepc=0x40, mcause=0x80000007, mstatus=0x80.
//  3 Priority: ext+timer both pending, mie=0x880 -> mcause=0x8000000B.
//  4 Load stall: pend with ld_stall=1 for 3 cycles -> interrupt=0 those cycles, asserts cycle ld_stall drops.
//  5 MRET: mepc=0x44, MPIE=1, is_mret=1 -> same cycle epc_taken=1, redirect_pc=0x44; next mstatus=0x88.
//  6 Collision: interrupt with is_mret + csrrw mie=0 same cycle -> entry taken, mepc=pc_ex, mie unchanged.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map,
// field positions, cause codes, CSR operation and FSM state encodings.
package trap_pkg;

  localparam int TRAP_XLEN = 32;

  // Implemented machine CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MEI_BIT          = 11;
  localparam int MTI_BIT          = 7;

  // Interrupt cause codes (low bits of mcause)
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  // New CSR value for a read-modify-write style access
  function automatic logic [TRAP_XLEN-1:0] csr_update(
    input csr_op_e                op,
    input logic [TRAP_XLEN-1:0]   old_val,
    input logic [TRAP_XLEN-1:0]   wdata
  );
    logic [TRAP_XLEN-1:0] res;
    case (op)
      CSR_RW:  res = wdata;
      CSR_RS:  res = old_val | wdata;
      CSR_RC:  res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mcsr_regs.sv
// Machine CSR storage: read mux, RW/RS/RC software writes, interrupt
// pending sampling, and the hardware updates for trap entry and MRET.
module mcsr_regs
  import trap_pkg::*;
#(
  parameter int                  XLEN     = TRAP_XLEN,
  parameter logic [XLEN-1:0]     RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_we,
  input  logic            trap_enter,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [3:0]      trap_code,
  input  logic            mret,
  output logic [XLEN-1:0] csr_rdata,
  output logic            mstatus_mie,
  output logic [XLEN-1:0] irq_active,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic [XLEN-1:0] mstatus_r;
  logic [XLEN-1:0] mie_r;
  logic [XLEN-1:0] mip_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mip_nxt_s;
  logic [XLEN-1:0] wr_val_s;

  // Interrupt lines land in their mip bit positions; all other bits stay zero
  always_comb begin
    mip_nxt_s          = {XLEN{1'b0}};
    mip_nxt_s[MEI_BIT] = ext_irq;
    mip_nxt_s[MTI_BIT] = timer_irq;
  end

  // Read mux over implemented CSRs, zero elsewhere
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_r;
      CSR_MIE:     csr_rdata = mie_r;
      CSR_MTVEC:   csr_rdata = mtvec_r;
      CSR_MEPC:    csr_rdata = mepc_r;
      CSR_MCAUSE:  csr_rdata = mcause_r;
      CSR_MIP:     csr_rdata = mip_r;
      default:     csr_rdata = {XLEN{1'b0}};
    endcase
  end

  assign wr_val_s    = csr_update(csr_op_e'(csr_op), csr_rdata, csr_wdata);
  assign mstatus_mie = mstatus_r[MSTATUS_MIE_BIT];
  assign irq_active  = mie_r & mip_r;
  assign mtvec       = mtvec_r;
  assign mepc        = mepc_r;

  // CSR state: trap entry beats MRET beats software write
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_r <= {XLEN{1'b0}};
      mie_r     <= {XLEN{1'b0}};
      mip_r     <= {XLEN{1'b0}};
      mcause_r  <= {XLEN{1'b0}};
      mtvec_r   <= RESET_PC;
      mepc_r    <= RESET_PC;
    end else begin
      mip_r <= mip_nxt_s;
      if (trap_enter) begin
        mepc_r                       <= trap_epc;
        mcause_r                     <= {1'b1, {(XLEN-5){1'b0}}, trap_code};
        mstatus_r[MSTATUS_MPIE_BIT]  <= mstatus_r[MSTATUS_MIE_BIT];
        mstatus_r[MSTATUS_MIE_BIT]   <= 1'b0;
      end else if (mret) begin
        mstatus_r[MSTATUS_MIE_BIT]   <= mstatus_r[MSTATUS_MPIE_BIT];
        mstatus_r[MSTATUS_MPIE_BIT]  <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: mstatus_r <= wr_val_s;
          CSR_MIE:     mie_r     <= wr_val_s;
          CSR_MTVEC:   mtvec_r   <= {wr_val_s[XLEN-1:2], 2'b00};
          CSR_MEPC:    mepc_r    <= {wr_val_s[XLEN-1:2], 2'b00};
          CSR_MCAUSE:  mcause_r  <= wr_val_s;
          default:     mcause_r  <= mcause_r;
        endcase
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode interrupt/trap sequencer beside EX: decides trap entry
// and MRET return, drives the flush/redirect signals, and hosts the CSRs.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN     = TRAP_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] pc_if,
  input  logic            ld_stall,
  input  logic            is_mret,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            interrupt,
  output logic            epc_taken,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     state_r;
  trap_state_e     state_nxt_s;
  logic            mstatus_mie_s;
  logic [XLEN-1:0] irq_active_s;
  logic [XLEN-1:0] mtvec_s;
  logic [XLEN-1:0] mepc_s;
  logic            pend_s;
  logic [3:0]      code_s;
  logic            trap_enter_s;
  logic            mret_s;
  logic            csr_we_s;
  logic [XLEN-1:0] trap_epc_s;

  // Pending uses the registered MIE, so a same-cycle write cannot mask it
  assign pend_s     = mstatus_mie_s & (|irq_active_s);
  assign code_s     = irq_active_s[MEI_BIT] ? CAUSE_MEI : CAUSE_MTI;
  // A flushed EX slot means IF holds the oldest unfinished instruction
  assign trap_epc_s = ex_valid ? pc_ex : pc_if;
  // Trapped instructions re-execute, so their CSR write must not land
  assign csr_we_s   = (csr_op != 2'b00) & ex_valid & ~ld_stall & ~trap_enter_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and redirect/flush outputs; entry wins over MRET
  always_comb begin
    state_nxt_s  = state_r;
    interrupt    = 1'b0;
    epc_taken    = 1'b0;
    redirect_pc  = {XLEN{1'b0}};
    trap_enter_s = 1'b0;
    mret_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (pend_s && !ld_stall) begin
          interrupt    = 1'b1;
          trap_enter_s = 1'b1;
          state_nxt_s  = ST_REDIRECT;
        end else if (!pend_s && is_mret && ex_valid) begin
          epc_taken   = 1'b1;
          redirect_pc = mepc_s;
          mret_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        epc_taken   = 1'b1;
        redirect_pc = {mtvec_s[XLEN-1:2], 2'b00};
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  mcsr_regs #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_mcsr_regs (
    .clk         (clk),
    .rst         (rst),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_we      (csr_we_s),
    .trap_enter  (trap_enter_s),
    .trap_epc    (trap_epc_s),
    .trap_code   (code_s),
    .mret        (mret_s),
    .csr_rdata   (csr_rdata),
    .mstatus_mie (mstatus_mie_s),
    .irq_active  (irq_active_s),
    .mtvec       (mtvec_s),
    .mepc        (mepc_s)
  );

endmodule
